isp1761_bus_sequencer: RTL



---
 rtl/isp1761_pkg.sv | 16 +
 rtl/isp1761_bus_sequencer_if.sv | 37 +++
 rtl/isp1761_irq_sync.sv | 26 ++
 rtl/isp1761_bus_sequencer.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/isp1761_pkg.sv
// Shared types and widths for the ISP1761 bus sequencer slice.
package isp1761_pkg;

    localparam int CNT_W  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        HOLD    = 3'd3,
        RECOVER = 3'd4
    } state_t;

endpackage

// File: rtl/isp1761_bus_sequencer_if.sv
// Avalon-MM slave side plus pin-interface side of the ISP1761 bus sequencer.
interface isp1761_bus_sequencer_if;
    import isp1761_pkg::*;

    logic [ADDR_W-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [DATA_W-1:0] avs_writedata;
    logic [DATA_W-1:0] avs_readdata;
    logic              avs_waitrequest;
    logic              avs_irq;

    logic              s_cs_n;
    logic [ADDR_W-1:0] s_address;
    logic              s_write_n;
    logic              s_read_n;
    logic [DATA_W-1:0] s_writedata;
    logic [DATA_W-1:0] s_readdata;
    logic              s_hc_irq;

    // Sequencer side.
    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata, avs_waitrequest, avs_irq,
        output s_cs_n, s_address, s_write_n, s_read_n, s_writedata,
        input  s_readdata, s_hc_irq
    );

    // Fabric master plus pin-interface model side.
    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata, avs_waitrequest, avs_irq,
        input  s_cs_n, s_address, s_write_n, s_read_n, s_writedata,
        output s_readdata, s_hc_irq
    );

endinterface

// File: rtl/isp1761_irq_sync.sv
// Two-flop synchronizer for the raw host-controller interrupt.
module isp1761_irq_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic irq_in,
    output logic irq_out
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], irq_in};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign irq_out = sync_q[1];

endmodule

// File: rtl/isp1761_bus_sequencer.sv
// Avalon-MM to timed CS/RD/WR strobe sequencer for the ISP1761 pin interface.
// Define ISP1761_IRQ_SYNC_EN to pass s_hc_irq through a two-flop synchronizer.
module isp1761_bus_sequencer
    import isp1761_pkg::*;
#(
    parameter int SETUP_CYC   = 1,
    parameter int STROBE_CYC  = 3,
    parameter int HOLD_CYC    = 1,
    parameter int RECOVER_CYC = 2
) (
    input  logic                      csi_clk,
    input  logic                      csi_reset_n,
    isp1761_bus_sequencer_if.slave    bus
);

    localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD  = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] RECOVER_LD = CNT_W'((RECOVER_CYC > 0) ? RECOVER_CYC - 1 : 0);
    localparam bit               HAS_RECOVER = (RECOVER_CYC > 0);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              is_write_q, is_write_d;
    logic              cs_n_q, cs_n_d;
    logic              rd_n_q, rd_n_d;
    logic              wr_n_q, wr_n_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic req;
    logic cnt_zero;
    logic accept;

    assign req      = bus.avs_read | bus.avs_write;
    assign cnt_zero = (cnt_q == '0);
    assign accept   = (state_q == IDLE) && req;

    // State register, including the registered pin strobes and latched request.
    always_ff @(posedge csi_clk or negedge csi_reset_n) begin
        if (!csi_reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            is_write_q <= 1'b0;
            cs_n_q     <= 1'b1;
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_write_q <= is_write_d;
            cs_n_q     <= cs_n_d;
            rd_n_q     <= rd_n_d;
            wr_n_q     <= wr_n_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
        end
    end

    // Next-state: each timed state counts down to zero, then reloads for the next.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = SETUP;
                    cnt_d   = SETUP_LD;
                end
            end
            SETUP: begin
                if (cnt_zero) begin
                    state_d = STROBE;
                    cnt_d   = STROBE_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            STROBE: begin
                if (cnt_zero) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                if (cnt_zero) begin
                    if (HAS_RECOVER) begin
                        state_d = RECOVER;
                        cnt_d   = RECOVER_LD;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RECOVER: begin
                if (cnt_zero) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs: pin strobes are decoded from the next state so they leave a flop.
    always_comb begin
        is_write_d = accept ? bus.avs_write     : is_write_q;
        addr_d     = accept ? bus.avs_address   : addr_q;
        wdata_d    = accept ? bus.avs_writedata : wdata_q;
        cs_n_d     = !(state_d inside {SETUP, STROBE, HOLD});
        rd_n_d     = !((state_d == STROBE) && !is_write_d);
        wr_n_d     = !((state_d == STROBE) && is_write_d);
        rdata_d    = rdata_q;
        if ((state_q == STROBE) && cnt_zero && !is_write_q) begin
            rdata_d = bus.s_readdata;
        end
    end

    assign bus.avs_waitrequest = !((state_q == HOLD) && cnt_zero);
    assign bus.avs_readdata    = rdata_q;
    assign bus.s_cs_n          = cs_n_q;
    assign bus.s_read_n        = rd_n_q;
    assign bus.s_write_n       = wr_n_q;
    assign bus.s_address       = addr_q;
    assign bus.s_writedata     = wdata_q;

`ifdef ISP1761_IRQ_SYNC_EN
    logic irq_sync;

    isp1761_irq_sync u_irq_sync (
        .clk     (csi_clk),
        .rst_n   (csi_reset_n),
        .irq_in  (bus.s_hc_irq),
        .irq_out (irq_sync)
    );

    assign bus.avs_irq = irq_sync;
`else
    assign bus.avs_irq = bus.s_hc_irq;
`endif

endmodule
